gpio_input_debounce: RTL and testbench

//   Input-side companion to the SoC GPIO write path. Synchronises and debounces raw

---
 rtl/gpio_input_debounce.sv | 54 +++++
 tb/tb_gpio_input_debounce.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/gpio_input_debounce.sv
// gpio_input_debounce: synchronise, debounce and queue change events for raw GPIO pads
module gpio_input_debounce #(
  parameter int WIDTH = 3,
  parameter int DEBOUNCE_CYCLES = 50000
) (
  input  logic               i_clk,
  input  logic               i_reset,
  input  logic [WIDTH-1:0]   i_gpio,
  output logic [WIDTH-1:0]   o_level,
  output logic [WIDTH-1:0]   o_rise,
  output logic [WIDTH-1:0]   o_fall,
  output logic               o_evt_valid,
  output logic [2*WIDTH-1:0] o_evt_data,
  input  logic               i_evt_ready,
  output logic               o_evt_overflow,
  input  logic               i_ovf_clear
);
  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  logic [WIDTH-1:0] s1, s2, flip, flip_mask;
  logic [WIDTH-1:0][CNT_W-1:0] cnt;
  always_comb begin
    flip_mask = o_rise | o_fall;
    flip = '0;
    for (int b = 0; b < WIDTH; b++) flip[b] = (s2[b] != o_level[b]) && (cnt[b] == LAST);
  end
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      s1 <= '0;
      s2 <= '0;
      cnt <= '0;
      o_level <= '0;
      o_rise <= '0;
      o_fall <= '0;
      o_evt_valid <= 1'b0;
      o_evt_data <= '0;
      o_evt_overflow <= 1'b0;
    end else begin
      s1 <= i_gpio;
      s2 <= s1;
      for (int b = 0; b < WIDTH; b++) cnt[b] <= (s2[b] == o_level[b] || flip[b]) ? '0 : cnt[b] + 1'b1;
      o_level <= o_level ^ flip;
      o_rise <= flip & s2;
      o_fall <= flip & ~s2;
      if (flip_mask != '0 && (!o_evt_valid || i_evt_ready)) begin
        o_evt_valid <= 1'b1;
        o_evt_data <= {flip_mask, o_level};
      end else if (i_evt_ready) begin
        o_evt_valid <= 1'b0;
      end
      o_evt_overflow <= (flip_mask != '0 && o_evt_valid && !i_evt_ready) || (o_evt_overflow && !i_ovf_clear);
    end
  end
endmodule

// File: tb/tb_gpio_input_debounce.sv
// tb_gpio_input_debounce: directed plus random checks of the debouncer against a window-based model
module tb_gpio_input_debounce;
  localparam int W = 3;
  localparam int D = 4;
  logic clk = 1'b0;
  logic rst, ready, clr;
  logic [W-1:0] gpio;
  logic [W-1:0] level, rise, fall;
  logic valid, ovf;
  logic [2*W-1:0] data;
  int vectors = 0;
  int miscompares = 0;
  gpio_input_debounce #(.WIDTH(W), .DEBOUNCE_CYCLES(D)) dut (
    .i_clk(clk),
    .i_reset(rst),
    .i_gpio(gpio),
    .o_level(level),
    .o_rise(rise),
    .o_fall(fall),
    .o_evt_valid(valid),
    .o_evt_data(data),
    .i_evt_ready(ready),
    .o_evt_overflow(ovf),
    .i_ovf_clear(clr)
  );
  always #5 clk = ~clk;
  logic [W-1:0] p1, p2, m_level, m_rise, m_fall;
  logic m_valid, m_ovf;
  logic [2*W-1:0] m_data;
  logic [W-1:0] seen[$];
  always @(posedge clk) begin
    logic [W-1:0] fl, fm;
    logic stable;
    if (rst) begin
      p1 = '0;
      p2 = '0;
      m_level = '0;
      m_rise = '0;
      m_fall = '0;
      m_valid = 1'b0;
      m_ovf = 1'b0;
      m_data = '0;
      seen.delete();
    end else begin
      seen.push_back(p2);
      if (seen.size() > D) void'(seen.pop_front());
      fl = '0;
      for (int b = 0; b < W; b++) begin
        stable = (seen.size() == D);
        foreach (seen[j]) if (seen[j][b] == m_level[b]) stable = 1'b0;
        fl[b] = stable;
      end
      fm = m_rise | m_fall;
      if (fm != '0 && m_valid && !ready) m_ovf = 1'b1;
      else if (clr) m_ovf = 1'b0;
      if (fm != '0 && (!m_valid || ready)) begin
        m_valid = 1'b1;
        m_data = {fm, m_level};
      end else if (ready) begin
        m_valid = 1'b0;
      end
      m_rise = fl & ~m_level;
      m_fall = fl & m_level;
      m_level = m_level ^ fl;
      p2 = p1;
      p1 = gpio;
    end
  end
  logic armed = 1'b0;
  always @(negedge clk) begin
    if (armed) begin
      vectors++;
      if ({level, rise, fall, valid, data, ovf} !== {m_level, m_rise, m_fall, m_valid, m_data, m_ovf}) begin
        miscompares++;
        $display("FAIL model t=%0t got lvl=%b r=%b f=%b v=%b d=%b o=%b exp lvl=%b r=%b f=%b v=%b d=%b o=%b",
                 $time, level, rise, fall, valid, data, ovf, m_level, m_rise, m_fall, m_valid, m_data, m_ovf);
      end
    end
  end
  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s got=%0h exp=%0h", name, got, exp);
    end
  endtask
  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask
  initial begin
    rst = 1'b1;
    gpio = '0;
    ready = 1'b0;
    clr = 1'b0;
    cyc(10);
    armed = 1'b1;
    chk("reset_all_zero", 32'({level, rise, fall, valid, data, ovf}), 32'd0);
    rst = 1'b0;
    gpio = 3'b001;
    cyc(5);
    chk("rise0_not_yet", 32'(level), 32'b000);
    cyc(1);
    chk("rise0_level", 32'(level), 32'b001);
    chk("rise0_pulse", 32'(rise), 32'b001);
    cyc(1);
    chk("rise0_pulse_gone", 32'(rise), 32'b000);
    chk("rise0_evt", 32'({valid, data}), 32'b1_001_001);
    cyc(3);
    chk("rise0_evt_held", 32'({valid, data}), 32'b1_001_001);
    ready = 1'b1;
    cyc(1);
    ready = 1'b0;
    chk("rise0_popped", 32'(valid), 32'd0);
    gpio = 3'b011;
    cyc(3);
    gpio = 3'b001;
    cyc(10);
    chk("glitch_level", 32'(level), 32'b001);
    chk("glitch_no_evt", 32'(valid), 32'd0);
    gpio = 3'b000;
    cyc(8);
    ready = 1'b1;
    cyc(1);
    ready = 1'b0;
    chk("fall0_level", 32'({level, valid}), 32'd0);
    gpio = 3'b101;
    cyc(6);
    chk("dual_rise", 32'({level, rise, fall}), 32'b101_101_000);
    cyc(1);
    chk("dual_evt", 32'({valid, data}), 32'b1_101_101);
    ready = 1'b1;
    cyc(1);
    ready = 1'b0;
    chk("dual_popped", 32'(valid), 32'd0);
    gpio = 3'b100;
    cyc(7);
    chk("ovf_first_evt", 32'({valid, data, ovf}), 32'b1_001_100_0);
    gpio = 3'b110;
    cyc(7);
    chk("ovf_set_held", 32'({valid, data, ovf}), 32'b1_001_100_1);
    chk("ovf_level", 32'(level), 32'b110);
    ready = 1'b1;
    cyc(1);
    ready = 1'b0;
    chk("ovf_pop", 32'({valid, ovf}), 32'b01);
    clr = 1'b1;
    cyc(1);
    clr = 1'b0;
    chk("ovf_clear", 32'(ovf), 32'd0);
    gpio = 3'b010;
    cyc(3);
    rst = 1'b1;
    cyc(2);
    rst = 1'b0;
    chk("midreset_zero", 32'({level, rise, fall, valid, data, ovf}), 32'd0);
    cyc(5);
    chk("redebounce_wait", 32'({level, valid}), 32'd0);
    cyc(1);
    chk("redebounce_rise", 32'({level, rise}), 32'b010_010);
    cyc(2);
    for (int i = 0; i < 3000; i++) begin
      int rate;
      rate = (i / 200) % 2 == 0 ? 3 : 20;
      for (int b = 0; b < W; b++) if ($urandom_range(0, rate - 1) == 0) gpio[b] = ~gpio[b];
      ready = 1'($urandom_range(0, 1));
      clr = ($urandom_range(0, 7) == 0);
      rst = ($urandom_range(0, 299) == 0);
      cyc(1);
    end
    rst = 1'b0;
    cyc(2);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
